// File: rtl/mul_arb_pkg.sv
// Shared definitions for the multiplier arbiter: state encoding and a width helper.
package mul_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LDA  = 3'd1,
    ST_LDB  = 3'd2,
    ST_ACC  = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  // Index width for a set of v entries; never narrower than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/mul_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr, wrapping.
module rr_pick
  import mul_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    winner_idx,
  output logic             any
);

  logic [PW-1:0] sel;

  // Scan from farthest to nearest so the request closest to ptr overwrites the rest.
  always_comb begin
    winner_idx = '0;
    any        = 1'b0;
    sel        = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sel = PW'((int'(ptr) + k) % N_REQ);
      if (req[sel]) begin
        winner_idx = sel;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter and sequencer sharing one repeated-addition multiplier datapath.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       result,
  output logic                   busy,
  output logic [WIDTH-1:0]       data_out,
  output logic                   lda,
  output logic                   ldb,
  output logic                   ldp,
  output logic                   clrp,
  output logic                   decb,
  input  logic [WIDTH-1:0]       p_in,
  input  logic                   eqz
);

  localparam int PW = clog2(N_REQ);

  // Handshake: a requester raises req with stable a_in/b_in and keeps them until
  // it sees its done bit; gnt marks ownership for the whole transaction, req
  // changes mid-transaction are ignored, and done is a single-cycle pulse.

  state_t        state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [PW-1:0] winner_idx;
  logic          any;

  rr_pick #(
    .N_REQ(N_REQ),
    .PW   (PW)
  ) u_pick (
    .req       (req),
    .ptr       (ptr_q),
    .winner_idx(winner_idx),
    .any       (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    result_d = result_q;
    gnt      = '0;
    done     = '0;
    busy     = (state_q != ST_IDLE);
    data_out = '0;
    lda      = 1'b0;
    ldb      = 1'b0;
    ldp      = 1'b0;
    clrp     = 1'b0;
    decb     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          owner_d = winner_idx;
          state_d = ST_LDA;
        end
      end
      ST_LDA: begin
        gnt[owner_q] = 1'b1;
        lda          = 1'b1;
        data_out     = a_in[int'(owner_q)*WIDTH +: WIDTH];
        state_d      = ST_LDB;
      end
      ST_LDB: begin
        gnt[owner_q] = 1'b1;
        ldb          = 1'b1;
        clrp         = 1'b1;
        data_out     = b_in[int'(owner_q)*WIDTH +: WIDTH];
        state_d      = ST_ACC;
      end
      ST_ACC: begin
        // P already holds the full product on the cycle B reaches zero.
        gnt[owner_q] = 1'b1;
        ldp          = ~eqz;
        decb         = ~eqz;
        if (eqz) begin
          result_d = p_in;
          state_d  = ST_FIN;
        end
      end
      ST_FIN: begin
        gnt[owner_q]  = 1'b1;
        done[owner_q] = 1'b1;
        ptr_d         = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign result = result_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: behavioural datapath plant, directed transactions, result scoreboard.
module tb_mul_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   a_in;
  logic [N*W-1:0]   b_in;
  logic [N-1:0]     gnt;
  logic [N-1:0]     done;
  logic [W-1:0]     result;
  logic             busy;
  logic [W-1:0]     data_out;
  logic             lda, ldb, ldp, clrp, decb;
  logic [W-1:0]     p_in;
  logic             eqz;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  int           exp_idx_q[$];

  mul_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done(done), .result(result), .busy(busy), .data_out(data_out),
    .lda(lda), .ldb(ldb), .ldp(ldp), .clrp(clrp), .decb(decb),
    .p_in(p_in), .eqz(eqz)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got hang required finish");
    $fatal(1, "timeout");
  end

  // ---------------- datapath plant ----------------
  logic [W-1:0] dp_a = '0, dp_b = '0, dp_p = '0;
  always @(posedge clk) begin
    if (lda) dp_a <= data_out;
    if (ldb) dp_b <= data_out;
    else if (decb) dp_b <= dp_b - 1'b1;
    if (clrp) dp_p <= '0;
    else if (ldp) dp_p <= dp_p + dp_a;
  end
  assign p_in = dp_p;
  assign eqz  = (dp_b == '0);

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {18'd0, gnt, done, result, busy, data_out, lda, ldb, ldp, clrp, decb};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && done != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {60'd0, done}, 64'd0);
      end else begin
        logic [W-1:0] e;
        int           ei;
        e  = exp_q.pop_front();
        ei = exp_idx_q.pop_front();
        chk("sb_done_owner", {60'd0, done}, 64'(1 << ei));
        chk("sb_result", {48'd0, result}, {48'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] prod;
    prod = a * b;
    exp_q.push_back(prod);
    exp_idx_q.push_back(idx);
  endtask

  task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[idx*W +: W] = a;
    b_in[idx*W +: W] = b;
  endtask

  // One requester alone: checks grant latency, gnt hold, ldp/decb counts and done timing.
  task automatic run_txn(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc, n_ldp, n_decb;
    bit seen, held;
    @(negedge clk);
    set_ops(idx, a, b);
    req = '0;
    req[idx] = 1'b1;
    push_exp(idx, a, b);
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (gnt != '0) seen = 1;
    end
    chk("gnt_latency", 64'(cyc), 64'd1);
    chk("gnt_onehot", {60'd0, gnt}, 64'(1 << idx));
    cyc = 1; n_ldp = 0; n_decb = 0; seen = 0; held = 1;
    while (!seen && cyc < int'(b) + 40) begin
      n_ldp  += int'(ldp);
      n_decb += int'(decb);
      @(negedge clk);
      cyc++;
      if (gnt != 4'(1 << idx)) held = 0;
      if (done != '0) seen = 1;
    end
    chk("done_cycle", 64'(cyc), 64'(int'(b) + 4));
    chk("gnt_held", 64'(held), 64'd1);
    chk("ldp_count", 64'(n_ldp), 64'(b));
    chk("decb_count", 64'(n_decb), 64'(b));
    req = '0;
    @(negedge clk);
    chk("back_to_idle", {62'd0, busy, |gnt}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, last_done;
    bit seen;
    rst = 1'b1; req = '0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: everything quiet.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", out_vec(), 64'd0);
    end

    run_txn(2, 16'd7, 16'd3);        // 21, done at cycle 7
    run_txn(1, 16'd9, 16'd0);        // B=0 -> 0, no ldp/decb

    // All four requesting from reset with B=1: grant order 0,1,2,3,0.
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_ops(i, 16'(16'h11 * (i + 1)), 16'd1);
    req = '1;
    for (int t = 0; t < 5; t++) push_exp(t % N, 16'(16'h11 * ((t % N) + 1)), 16'd1);
    @(negedge clk);
    rst = 1'b0;
    last_done = -100;
    for (int t = 0; t < 5; t++) begin
      cyc = 0; seen = 0;
      while (!seen && cyc < 10) begin
        @(negedge clk);
        cyc++;
        if (gnt != '0) seen = 1;
      end
      chk("rr_order", {60'd0, gnt}, 64'(1 << (t % N)));
      if (t > 0) chk("done_to_gnt", 64'(cyc), 64'd2);
      cyc = 1; seen = 0;
      while (!seen && cyc < 20) begin
        @(negedge clk);
        cyc++;
        if (done != '0) seen = 1;
      end
      chk("rr_txn_len", 64'(cyc), 64'd5);
      if (t == 4) req = '0;
    end
    @(negedge clk);

    run_txn(0, 16'hFFFF, 16'd2);     // wraps to 0xFFFE

    // Reset during ACC of a B=10 transaction.
    @(negedge clk);
    set_ops(3, 16'd5, 16'd10);
    req = 4'b1000;
    cyc = 0; seen = 0;
    while (!seen && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (gnt != '0) seen = 1;
    end
    chk("abort_gnt", {60'd0, gnt}, 64'h8);
    repeat (2) @(negedge clk);
    chk("abort_in_acc", {63'd0, ldp}, 64'd1);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    chk("abort_reset_outputs", out_vec(), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_quiet", out_vec(), 64'd0);
    end
    run_txn(3, 16'd5, 16'd10);       // re-request -> 50

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
